// File: rtl/register_file.sv
// 32 x 32-bit register file with x0 hardwired to zero, one shared write port and
// two registered read ports. Each cycle is either a read or a write, never both.
module register_file (
  input  logic        CK_REF,
  input  logic        RST_N,
  input  logic        REG_RD_WRN,
  input  logic [4:0]  RS1_REG_OFFSET,
  input  logic [4:0]  RS2_REG_OFFSET,
  input  logic [4:0]  RD_REG_OFFSET,
  input  logic [31:0] REG_DATA_IN,
  output logic [31:0] RS1_DATA_OUT,
  output logic [31:0] RS2_DATA_OUT
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int N_REGS = 32;

  // x0 has no storage; only x1..x31 exist as flops
  logic [DATA_W-1:0] regs_q [1:N_REGS-1];
  logic              wr_en;

  assign wr_en = !REG_RD_WRN && (RD_REG_OFFSET != '0);

  function automatic logic [DATA_W-1:0] read_reg(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 1; i < N_REGS; i++) begin
      if (idx == IDX_W'(i)) val = regs_q[i];
    end
    return val;
  endfunction

  // Storage update: reset wins over any write on the same edge
  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      for (int i = 1; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < N_REGS; i++) begin
        if (RD_REG_OFFSET == IDX_W'(i)) regs_q[i] <= REG_DATA_IN;
      end
    end
  end

  // Read stage: outputs update only on read cycles and hold through writes
  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      RS1_DATA_OUT <= '0;
      RS2_DATA_OUT <= '0;
    end else if (REG_RD_WRN) begin
      RS1_DATA_OUT <= read_reg(RS1_REG_OFFSET);
      RS2_DATA_OUT <= read_reg(RS2_REG_OFFSET);
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: the driver queues expected outputs per edge,
// a negedge monitor pops and compares them against the registered read ports.
module tb_register_file;

  logic        CK_REF = 1'b0;
  logic        RST_N;
  logic        REG_RD_WRN;
  logic [4:0]  RS1_REG_OFFSET;
  logic [4:0]  RS2_REG_OFFSET;
  logic [4:0]  RD_REG_OFFSET;
  logic [31:0] REG_DATA_IN;
  logic [31:0] RS1_DATA_OUT;
  logic [31:0] RS2_DATA_OUT;

  register_file dut (
    .CK_REF         (CK_REF),
    .RST_N          (RST_N),
    .REG_RD_WRN     (REG_RD_WRN),
    .RS1_REG_OFFSET (RS1_REG_OFFSET),
    .RS2_REG_OFFSET (RS2_REG_OFFSET),
    .RD_REG_OFFSET  (RD_REG_OFFSET),
    .REG_DATA_IN    (REG_DATA_IN),
    .RS1_DATA_OUT   (RS1_DATA_OUT),
    .RS2_DATA_OUT   (RS2_DATA_OUT)
  );

  always #5 CK_REF = ~CK_REF;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk   = 1'b0;
  logic chk_q = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   done    = 1'b0;

  // Distinct per-register pattern so address decoding faults show up
  function automatic logic [31:0] pat(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb, ~kb, 8'hC3, 8'(k * 7)};
  endfunction

  // Drive one cycle's inputs; optionally queue the outputs expected after its edge
  task automatic step(input logic rst_n, input logic rdwrn,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] din,
                      input logic do_chk, input logic [31:0] e1,
                      input logic [31:0] e2, input string name);
    exp_t e;
    RST_N          = rst_n;
    REG_RD_WRN     = rdwrn;
    RS1_REG_OFFSET = rs1;
    RS2_REG_OFFSET = rs2;
    RD_REG_OFFSET  = rd;
    REG_DATA_IN    = din;
    chk            = do_chk;
    if (do_chk) begin
      e.e1 = e1; e.e2 = e2; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge CK_REF);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] din);
    step(1'b1, 1'b0, 5'd0, 5'd0, rd, din, 1'b0, '0, '0, "");
  endtask

  task automatic rd_chk(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] e1, input logic [31:0] e2, input string name);
    step(1'b1, 1'b1, rs1, rs2, 5'd0, 32'h0, 1'b1, e1, e2, name);
  endtask

  always @(posedge CK_REF) chk_q <= chk;

  always @(negedge CK_REF) begin
    if (chk_q) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL no_expectation: output edge with empty scoreboard");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (RS1_DATA_OUT === e.e1 && RS2_DATA_OUT === e.e2) n_pass++;
        else $display("FAIL %s: rs1=%h rs2=%h expected rs1=%h rs2=%h",
                      e.name, RS1_DATA_OUT, RS2_DATA_OUT, e.e1, e.e2);
      end
    end
  end

  initial begin
    // Reset edge: outputs clear immediately
    step(1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, "reset_outputs");
    rd_chk(5'd0, 5'd1, 32'h0, 32'h0, "post_reset_read_0_1");
    rd_chk(5'd31, 5'd17, 32'h0, 32'h0, "post_reset_read_31_17");

    // Writes to x0 are discarded
    wr(5'd0, 32'hFFFF_FFFF);
    rd_chk(5'd0, 5'd0, 32'h0, 32'h0, "x0_write_discarded");

    // All-ones sweep, same index on both ports, read right after the write edge
    for (int k = 1; k < 32; k++) begin
      wr(5'(k), 32'hFFFF_FFFF);
      rd_chk(5'(k), 5'(k), 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("sweep_ones_x%0d", k));
    end

    // Distinct contents everywhere, then cross-read pairs
    for (int k = 1; k < 32; k++) wr(5'(k), pat(k));
    for (int k = 1; k < 32; k++)
      rd_chk(5'(k), 5'(32 - k), pat(k), (k == 0) ? 32'h0 : pat(32 - k),
             $sformatf("pattern_x%0d_x%0d", k, 32 - k));
    rd_chk(5'd0, 5'd9, 32'h0, pat(9), "pattern_x0_x9");

    // Named values, then a write cycle must leave the outputs held
    wr(5'd5, 32'h1234_5678);
    wr(5'd6, 32'hDEAD_BEEF);
    rd_chk(5'd5, 5'd6, 32'h1234_5678, 32'hDEAD_BEEF, "read_x5_x6");
    step(1'b1, 1'b0, 5'd1, 5'd2, 5'd7, 32'h0BAD_F00D, 1'b1,
         32'h1234_5678, 32'hDEAD_BEEF, "hold_during_write");
    rd_chk(5'd7, 5'd7, 32'h0BAD_F00D, 32'h0BAD_F00D, "read_x7_after_hold");

    // A read cycle must not write, whatever RD and data say
    step(1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 32'hCAFE_CAFE, 1'b1, pat(8), 32'h0, "read_no_write_a");
    rd_chk(5'd8, 5'd8, pat(8), pat(8), "read_no_write_b");

    // Reset during a write cycle: no write, outputs and storage clear
    step(1'b0, 1'b0, 5'd5, 5'd6, 5'd3, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, "reset_mid_op_outputs");
    rd_chk(5'd3, 5'd31, 32'h0, 32'h0, "after_reset_x3_x31");
    rd_chk(5'd5, 5'd6, 32'h0, 32'h0, "after_reset_x5_x6");
    wr(5'd3, 32'h0000_0001);
    rd_chk(5'd3, 5'd4, 32'h0000_0001, 32'h0, "rewrite_x3");

    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, '0, '0, "");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, '0, '0, "");
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL watchdog: run did not complete, expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
